// File: rtl/verinject_injection_sequencer.sv
// Fault-injection sequencer: accepts one bit-flip request, waits a programmed delay,
// then drives the target bit index onto the shared injector bus for a programmed hold.
module verinject_injection_sequencer #(
   parameter logic [31:0] IDLE_STATE = 32'hFFFF_FFFF,
   parameter int          CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_bit,
   input  logic [CNT_W-1:0] req_delay,
   input  logic [CNT_W-1:0] req_hold,
   input  logic             abort,
   output logic [31:0]      verinject__injector_state,
   output logic             busy,
   output logic             done_pulse,
   output logic [15:0]      inject_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_INJECT} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [CNT_W-1:0] hold_q, hold_next;
   logic [CNT_W-1:0] req_hold_m1;
   logic [31:0]      bit_q, bit_next;
   logic [31:0]      bus_next;
   logic             done_next;
   logic [15:0]      count_next;

   // A zero hold still gives one cycle of injection.
   assign req_hold_m1 = (req_hold == '0) ? '0 : req_hold - CNT_ONE;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      bit_next   = bit_q;
      hold_next  = hold_q;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               bit_next  = req_bit;
               hold_next = req_hold_m1;
               if (req_delay == '0) begin
                  state_next = ST_INJECT;
                  cnt_next   = req_hold_m1;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = req_delay - CNT_ONE;
               end
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt == '0) begin
               state_next = ST_INJECT;
               cnt_next   = hold_q;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end
         ST_INJECT: begin
            if (abort || cnt == '0) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Only a natural expiry of INJECT counts as a completed injection; abort wins.
   always_comb begin
      req_ready  = (state == ST_IDLE);
      bus_next   = IDLE_STATE;
      if (state_next == ST_INJECT) begin
         bus_next = (state == ST_IDLE) ? req_bit : bit_q;
      end
      done_next  = (state == ST_INJECT) && !abort && (cnt == '0);
      count_next = inject_count;
      if (done_next && inject_count != 16'hFFFF) begin
         count_next = inject_count + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt                       <= '0;
         hold_q                    <= '0;
         bit_q                     <= IDLE_STATE;
         verinject__injector_state <= IDLE_STATE;
         busy                      <= 1'b0;
         done_pulse                <= 1'b0;
         inject_count              <= 16'd0;
      end else begin
         cnt                       <= cnt_next;
         hold_q                    <= hold_next;
         bit_q                     <= bit_next;
         verinject__injector_state <= bus_next;
         busy                      <= (state_next != ST_IDLE);
         done_pulse                <= done_next;
         inject_count              <= count_next;
      end
   end

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Directed bench for the injection sequencer: timing windows, abort, back-to-back,
// saturation and asynchronous reset, each scenario checked against hand-computed values.
module tb_verinject_injection_sequencer;

   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_bit;
   logic [31:0] req_delay;
   logic [31:0] req_hold;
   logic        abort;
   logic [31:0] verinject__injector_state;
   logic        busy;
   logic        done_pulse;
   logic [15:0] inject_count;

   int n_checks;
   int n_fail;

   verinject_injection_sequencer #(.IDLE_STATE(IDLE), .CNT_W(32)) dut (
      .clock                    (clock),
      .reset_n                  (reset_n),
      .req_valid                (req_valid),
      .req_ready                (req_ready),
      .req_bit                  (req_bit),
      .req_delay                (req_delay),
      .req_hold                 (req_hold),
      .abort                    (abort),
      .verinject__injector_state(verinject__injector_state),
      .busy                     (busy),
      .done_pulse               (done_pulse),
      .inject_count             (inject_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic [31:0] b, input logic [31:0] d, input logic [31:0] h);
      req_valid = 1'b1;
      req_bit   = b;
      req_delay = d;
      req_hold  = h;
      step();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      n_checks++;
      if (verinject__injector_state !== IDLE) begin
         n_fail++; $display("FAIL reset_bus: got %h expected %h", verinject__injector_state, IDLE);
      end
      n_checks++;
      if (inject_count !== 16'd0 || busy !== 1'b0 || done_pulse !== 1'b0) begin
         n_fail++; $display("FAIL reset_regs: got count=%h busy=%b done=%b expected 0/0/0", inject_count, busy, done_pulse);
      end
      reset_n = 1'b1;
      step();
      n_checks++;
      if (req_ready !== 1'b1 || verinject__injector_state !== IDLE) begin
         n_fail++; $display("FAIL reset_ready: got ready=%b bus=%h expected 1/%h", req_ready, verinject__injector_state, IDLE);
      end
   endtask

   task automatic test_single();
      offer(32'd37, 32'd0, 32'd1);
      n_checks++;
      if (verinject__injector_state !== 32'd37 || busy !== 1'b1 || req_ready !== 1'b0) begin
         n_fail++; $display("FAIL single_active: got bus=%h busy=%b ready=%b expected 25/1/0", verinject__injector_state, busy, req_ready);
      end
      step();
      n_checks++;
      if (verinject__injector_state !== IDLE || done_pulse !== 1'b1 || inject_count !== 16'd1) begin
         n_fail++; $display("FAIL single_done: got bus=%h done=%b count=%0d expected %h/1/1", verinject__injector_state, done_pulse, inject_count, IDLE);
      end
      step();
      n_checks++;
      if (done_pulse !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL single_pulse_width: got done=%b busy=%b expected 0/0", done_pulse, busy);
      end
   endtask

   task automatic test_delay_hold();
      logic [31:0] exp_bus;
      offer(32'd5, 32'd3, 32'd4);
      for (int k = 0; k < 7; k++) begin
         if (k > 0) step();
         exp_bus = (k >= 3) ? 32'd5 : IDLE;
         n_checks++;
         if (verinject__injector_state !== exp_bus || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL delay_window[%0d]: got bus=%h busy=%b ready=%b expected %h/1/0", k, verinject__injector_state, busy, req_ready, exp_bus);
         end
      end
      step();
      n_checks++;
      if (verinject__injector_state !== IDLE || done_pulse !== 1'b1 || busy !== 1'b0 || inject_count !== 16'd2) begin
         n_fail++; $display("FAIL delay_done: got bus=%h done=%b busy=%b count=%0d expected %h/1/0/2", verinject__injector_state, done_pulse, busy, inject_count, IDLE);
      end
   endtask

   task automatic test_hold_zero();
      offer(32'd9, 32'd0, 32'd0);
      n_checks++;
      if (verinject__injector_state !== 32'd9) begin
         n_fail++; $display("FAIL hold0_bus: got %h expected %h", verinject__injector_state, 32'd9);
      end
      step();
      n_checks++;
      if (verinject__injector_state !== IDLE || done_pulse !== 1'b1 || inject_count !== 16'd3) begin
         n_fail++; $display("FAIL hold0_done: got bus=%h done=%b count=%0d expected %h/1/3", verinject__injector_state, done_pulse, inject_count, IDLE);
      end
   endtask

   task automatic test_back_to_back();
      offer(32'd11, 32'd0, 32'd2);
      step();
      n_checks++;
      if (verinject__injector_state !== 32'd11) begin
         n_fail++; $display("FAIL b2b_hold2: got %h expected %h", verinject__injector_state, 32'd11);
      end
      step();
      n_checks++;
      if (done_pulse !== 1'b1 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_done: got done=%b ready=%b expected 1/1", done_pulse, req_ready);
      end
      offer(32'd12, 32'd1, 32'd1);
      n_checks++;
      if (done_pulse !== 1'b0 || busy !== 1'b1 || verinject__injector_state !== IDLE) begin
         n_fail++; $display("FAIL b2b_accept: got done=%b busy=%b bus=%h expected 0/1/%h", done_pulse, busy, verinject__injector_state, IDLE);
      end
      step();
      n_checks++;
      if (verinject__injector_state !== 32'd12) begin
         n_fail++; $display("FAIL b2b_second_bus: got %h expected %h", verinject__injector_state, 32'd12);
      end
      step();
      n_checks++;
      if (done_pulse !== 1'b1 || inject_count !== 16'd5) begin
         n_fail++; $display("FAIL b2b_second_done: got done=%b count=%0d expected 1/5", done_pulse, inject_count);
      end
   endtask

   task automatic test_abort();
      offer(32'd20, 32'd3, 32'd2);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_checks++;
      if (verinject__injector_state !== IDLE || busy !== 1'b0 || req_ready !== 1'b1 || done_pulse !== 1'b0) begin
         n_fail++; $display("FAIL abort_wait: got bus=%h busy=%b ready=%b done=%b expected %h/0/1/0", verinject__injector_state, busy, req_ready, done_pulse, IDLE);
      end
      step();
      n_checks++;
      if (done_pulse !== 1'b0 || inject_count !== 16'd5) begin
         n_fail++; $display("FAIL abort_wait_count: got done=%b count=%0d expected 0/5", done_pulse, inject_count);
      end
      offer(32'd21, 32'd0, 32'd2);
      step();
      n_checks++;
      if (verinject__injector_state !== 32'd21) begin
         n_fail++; $display("FAIL abort_final_pre: got %h expected %h", verinject__injector_state, 32'd21);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_checks++;
      if (verinject__injector_state !== IDLE || done_pulse !== 1'b0 || inject_count !== 16'd5) begin
         n_fail++; $display("FAIL abort_final: got bus=%h done=%b count=%0d expected %h/0/5", verinject__injector_state, done_pulse, inject_count, IDLE);
      end
      abort = 1'b1;
      offer(32'd22, 32'd0, 32'd1);
      abort = 1'b0;
      n_checks++;
      if (verinject__injector_state !== 32'd22 || busy !== 1'b1) begin
         n_fail++; $display("FAIL abort_idle_accept: got bus=%h busy=%b expected %h/1", verinject__injector_state, busy, 32'd22);
      end
      step();
      n_checks++;
      if (done_pulse !== 1'b1 || inject_count !== 16'd6) begin
         n_fail++; $display("FAIL abort_idle_done: got done=%b count=%0d expected 1/6", done_pulse, inject_count);
      end
   endtask

   task automatic test_idle_bit();
      offer(IDLE, 32'd0, 32'd1);
      n_checks++;
      if (verinject__injector_state !== IDLE || busy !== 1'b1) begin
         n_fail++; $display("FAIL idle_bit_active: got bus=%h busy=%b expected %h/1", verinject__injector_state, busy, IDLE);
      end
      step();
      n_checks++;
      if (done_pulse !== 1'b1 || inject_count !== 16'd7) begin
         n_fail++; $display("FAIL idle_bit_done: got done=%b count=%0d expected 1/7", done_pulse, inject_count);
      end
   endtask

   task automatic test_saturation();
      force dut.inject_count = 16'hFFFE;
      #1;
      release dut.inject_count;
      step();
      offer(32'd1, 32'd0, 32'd1);
      step();
      n_checks++;
      if (inject_count !== 16'hFFFF) begin
         n_fail++; $display("FAIL sat_reach: got %h expected %h", inject_count, 16'hFFFF);
      end
      offer(32'd2, 32'd0, 32'd1);
      step();
      n_checks++;
      if (inject_count !== 16'hFFFF || done_pulse !== 1'b1) begin
         n_fail++; $display("FAIL sat_hold: got count=%h done=%b expected ffff/1", inject_count, done_pulse);
      end
   endtask

   task automatic test_reset_mid();
      offer(32'd30, 32'd0, 32'd5);
      step();
      n_checks++;
      if (verinject__injector_state !== 32'd30) begin
         n_fail++; $display("FAIL midreset_pre: got %h expected %h", verinject__injector_state, 32'd30);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (verinject__injector_state !== IDLE || busy !== 1'b0 || inject_count !== 16'd0) begin
         n_fail++; $display("FAIL midreset_async: got bus=%h busy=%b count=%0d expected %h/0/0", verinject__injector_state, busy, inject_count, IDLE);
      end
      #1;
      reset_n = 1'b1;
      step();
      n_checks++;
      if (done_pulse !== 1'b0 || req_ready !== 1'b1 || verinject__injector_state !== IDLE) begin
         n_fail++; $display("FAIL midreset_after: got done=%b ready=%b bus=%h expected 0/1/%h", done_pulse, req_ready, verinject__injector_state, IDLE);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      req_valid = 1'b0;
      req_bit   = 32'd0;
      req_delay = 32'd0;
      req_hold  = 32'd0;
      abort     = 1'b0;
      reset_n   = 1'b0;
      test_reset();
      test_single();
      test_delay_hold();
      test_hold_zero();
      test_back_to_back();
      test_abort();
      test_idle_bit();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
